// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM->WB pipeline register.
package wb_pkg;

  // Default widths; also the capacity of the payload struct fields.
  localparam int WB_DATA_W  = 32;
  localparam int WB_RADDR_W = 5;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_LD  = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [WB_DATA_W-1:0]  alu_out;
    logic [WB_DATA_W-1:0]  ld_data;
    logic [WB_RADDR_W-1:0] rd;
    logic                  reg_wen;
    logic                  wb_sel;
  } wb_payload_t;

endpackage

// File: rtl/wb_pipe_reg.sv
// Two-entry MEM->WB skid buffer with registered ready/valid and a writeback forwarding tap.
// Optional macro WB_PIPE_FWD_EN enables the forwarding tap; otherwise fwd_* are tied to 0.
module wb_pipe_reg
  import wb_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int RADDR_W = WB_RADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  M_alu_out,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic [RADDR_W-1:0] M_rd,
  input  logic               M_reg_wen,
  input  logic               M_wb_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  W_alu_out,
  output logic [DATA_W-1:0]  W_ld_data,
  output logic [RADDR_W-1:0] W_rd,
  output logic               W_reg_wen,
  output logic               W_wb_sel,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]  fwd_data
);

  // DATA_W/RADDR_W must not exceed the package field widths.
  wb_state_e   state_q, state_d;
  wb_payload_t main_q, main_d;
  wb_payload_t skid_q, skid_d;
  wb_payload_t in_pl;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        push, pop;

  always_comb begin
    in_pl                     = '0;
    in_pl.alu_out[DATA_W-1:0] = M_alu_out;
    in_pl.ld_data[DATA_W-1:0] = ld_data;
    in_pl.rd[RADDR_W-1:0]     = M_rd;
    in_pl.reg_wen             = M_reg_wen;
    in_pl.wb_sel              = M_wb_sel;
  end

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            main_d  = in_pl;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = in_pl;
          end else if (push) begin
            state_d = ST_FULL;
            skid_d  = in_pl;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Skid entry is promoted only after main has drained, keeping order.
          if (pop) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Handshake flags are registered copies of the next state.
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign W_alu_out = main_q.alu_out[DATA_W-1:0];
  assign W_ld_data = main_q.ld_data[DATA_W-1:0];
  assign W_rd      = main_q.rd[RADDR_W-1:0];
  assign W_reg_wen = main_q.reg_wen;
  assign W_wb_sel  = main_q.wb_sel;

`ifdef WB_PIPE_FWD_EN
  assign fwd_valid = out_valid_q && main_q.reg_wen && (W_rd != '0);
  assign fwd_rd    = W_rd;
  assign fwd_data  = (main_q.wb_sel == WB_SEL_LD) ? W_ld_data : W_alu_out;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Randomized and directed bench for wb_pipe_reg against a queue-based reference model.
module tb_wb_pipe_reg;

  logic        clk;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] M_alu_out, ld_data;
  logic [4:0]  M_rd;
  logic        M_reg_wen, M_wb_sel;
  logic [31:0] W_alu_out, W_ld_data, fwd_data;
  logic [4:0]  W_rd, fwd_rd;
  logic        W_reg_wen, W_wb_sel, fwd_valid;

  int errors = 0;
  int checks = 0;

  wb_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .M_alu_out(M_alu_out), .ld_data(ld_data), .M_rd(M_rd),
    .M_reg_wen(M_reg_wen), .M_wb_sel(M_wb_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .W_alu_out(W_alu_out), .W_ld_data(W_ld_data), .W_rd(W_rd),
    .W_reg_wen(W_reg_wen), .W_wb_sel(W_wb_sel),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an in-order FIFO of at most two accepted entries.
  typedef struct {
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  rd;
    logic        wen;
    logic        sel;
  } ent_t;

  ent_t q[$];
  bit   live = 0;

  always @(posedge clk) begin
    bit   do_pop, do_push;
    ent_t e;
    if (rst) begin
      q.delete();
      live = 1;
    end else if (flush) begin
      q.delete();
    end else if (live) begin
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && (q.size() < 2);
      e.alu = M_alu_out; e.ld = ld_data; e.rd = M_rd; e.wen = M_reg_wen; e.sel = M_wb_sel;
      if (do_pop) q.delete(0);
      if (do_push) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("W_alu_out", W_alu_out, q[0].alu);
        chk("W_ld_data", W_ld_data, q[0].ld);
        chk("W_rd", W_rd, q[0].rd);
        chk("W_reg_wen", W_reg_wen, q[0].wen);
        chk("W_wb_sel", W_wb_sel, q[0].sel);
      end
`ifdef WB_PIPE_FWD_EN
      chk("fwd_valid", fwd_valid, (q.size() > 0) && q[0].wen && (q[0].rd != 0));
      if (q.size() > 0) begin
        chk("fwd_rd", fwd_rd, q[0].rd);
        chk("fwd_data", fwd_data, q[0].sel ? q[0].ld : q[0].alu);
      end
`else
      chk("fwd_valid", fwd_valid, 0);
      chk("fwd_rd", fwd_rd, 0);
      chk("fwd_data", fwd_data, 0);
`endif
    end
  end

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] ld,
                       input logic [4:0] rd, input logic wen, input logic sel);
    in_valid = v; M_alu_out = alu; ld_data = ld; M_rd = rd; M_reg_wen = wen; M_wb_sel = sel;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_W_alu_out", W_alu_out, 0);
    chk("rst_W_rd", W_rd, 0);
    chk("rst_fwd_valid", fwd_valid, 0);

    // Single push from empty: one-cycle latency
    rst = 1'b0; out_ready = 1'b1;
    drive(1, 32'h0000_1234, 0, 5'd3, 1, 0);
    step();
    chk("lat_out_valid", out_valid, 1);
    chk("lat_W_alu_out", W_alu_out, 32'h1234);
    chk("lat_W_rd", W_rd, 3);
    in_valid = 1'b0;
    step();

    // Backpressure: A, B accepted; C held off until drain
    out_ready = 1'b0;
    drive(1, 32'h11, 0, 5'd1, 1, 0);
    step();
    chk("bp_A_in_ready", in_ready, 1);
    chk("bp_A_head", W_alu_out, 32'h11);
    drive(1, 32'h22, 0, 5'd2, 1, 0);
    step();
    chk("bp_full_in_ready", in_ready, 0);
    drive(1, 32'h33, 0, 5'd4, 1, 0);
    step();
    chk("bp_C_held_in_ready", in_ready, 0);
    chk("bp_head_still_A", W_alu_out, 32'h11);
    out_ready = 1'b1;
    step();
    chk("bp_out_B", W_alu_out, 32'h22);
    step();
    chk("bp_out_C", W_alu_out, 32'h33);
    in_valid = 1'b0;
    step();
    chk("bp_drained", out_valid, 0);

    // Flush while FULL with an incoming push
    out_ready = 1'b0;
    drive(1, 32'h44, 0, 5'd5, 1, 0);
    step();
    drive(1, 32'h55, 0, 5'd6, 1, 0);
    step();
    chk("fl_full", in_ready, 0);
    flush = 1'b1;
    drive(1, 32'h66, 0, 5'd7, 1, 0);
    step();
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      step();
      chk("fl_never_appears", out_valid, 0);
    end

    // Reset while FULL, with flush and push also asserted
    out_ready = 1'b0;
    drive(1, 32'h77, 32'h7, 5'd8, 1, 1);
    step();
    drive(1, 32'h88, 32'h8, 5'd9, 1, 0);
    step();
    rst = 1'b1; flush = 1'b1;
    drive(1, 32'h99, 32'h9, 5'd10, 1, 1);
    step();
    chk("rs_out_valid", out_valid, 0);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_W_alu_out", W_alu_out, 0);
    chk("rs_W_ld_data", W_ld_data, 0);
    chk("rs_W_rd", W_rd, 0);
    chk("rs_W_reg_wen", W_reg_wen, 0);
    chk("rs_W_wb_sel", W_wb_sel, 0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();

    // Forwarding tap
    out_ready = 1'b0;
    drive(1, 32'h5, 32'hDEAD_BEEF, 5'd7, 1, 1);
    step();
`ifdef WB_PIPE_FWD_EN
    chk("fw_valid", fwd_valid, 1);
    chk("fw_rd", fwd_rd, 7);
    chk("fw_data", fwd_data, 32'hDEAD_BEEF);
`else
    chk("fw_off_valid", fwd_valid, 0);
    chk("fw_off_rd", fwd_rd, 0);
    chk("fw_off_data", fwd_data, 0);
`endif
    out_ready = 1'b1;
    drive(1, 32'h6, 32'hDEAD_BEEF, 5'd0, 1, 1);
    step();
    chk("fw_rd0_W_rd", W_rd, 0);
    chk("fw_rd0_valid", fwd_valid, 0);
    in_valid = 1'b0;
    step();

    // Randomized traffic
    repeat (3000) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_pipe_reg.md
WB_PIPE_REG -- requirements
Module: wb_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the width of the ALU result and load data.
REQ-002 SHALL have parameter RADDR_W, default 5, the width of the destination register index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discards all held and incoming entries.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1, the upstream (MEM) handshake.
REQ-007 SHALL have ports M_alu_out input DATA_W, ld_data input DATA_W, M_rd input RADDR_W, M_reg_wen input 1 and M_wb_sel input 1 (0=ALU, 1=load) as the upstream payload.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1, the downstream (register-file write) handshake.
REQ-009 SHALL have ports W_alu_out output DATA_W, W_ld_data output DATA_W, W_rd output RADDR_W, W_reg_wen output 1 and W_wb_sel output 1 as the downstream payload.
REQ-010 SHALL have ports fwd_valid output 1, fwd_rd output RADDR_W and fwd_data output DATA_W as the forwarding tap (see Configuration).

Function
REQ-011 SHALL be a two-entry skid buffer (main + skid) with states EMPTY, ONE, FULL.
REQ-012 SHALL transfer upstream when in_valid && in_ready and downstream when out_valid && out_ready.
REQ-013 SHALL drive in_ready from a register, high in EMPTY and ONE and low in FULL, with no combinational path from out_ready.
REQ-014 SHALL drive out_valid high in ONE and FULL, and drive the W_* outputs directly from main-entry registers.
REQ-015 SHALL have a latency of one cycle: data accepted in cycle N appears on W_* in cycle N+1 when the buffer was EMPTY.
REQ-016 SHALL follow these transitions: EMPTY+push->ONE; ONE+push,no pop->FULL (payload to skid); ONE+push+pop->ONE (main replaced); ONE+pop,no push->EMPTY; FULL+pop->ONE (skid moves to main); all other cases hold.
REQ-017 SHALL preserve order: the skid entry is never presented before the main entry.
REQ-018 SHALL, on flush, enter EMPTY next cycle, drop any same-cycle push and pop, and set in_ready high; flush has priority over every handshake.
REQ-019 SHALL pass the payload unmodified, with no width conversion; M_rd==0 is carried as-is.
REQ-020 SHALL hold W_* stable while out_valid && !out_ready.

Reset
REQ-021 SHALL, with rst high at a clock edge, enter EMPTY and set in_ready=1, out_valid=0, and all W_*, skid and fwd_* registers to 0.
REQ-022 SHALL give rst priority over flush and over all handshakes; rst asserted mid-transfer discards both entries.

Configuration
REQ-023 SHALL, with macro WB_PIPE_FWD_EN defined, drive fwd_valid=out_valid&&W_reg_wen&&(W_rd!=0), fwd_rd=W_rd and fwd_data=(W_wb_sel ? W_ld_data : W_alu_out), all combinational from the main entry.
REQ-024 SHALL, without WB_PIPE_FWD_EN, keep the fwd_* ports and tie them to constant 0.

Structure
REQ-025 SHALL take the wb_sel encoding constants (WB_SEL_ALU=0, WB_SEL_LD=1), the default widths and the state encoding typedef from shared package wb_pkg.
REQ-026 SHALL have no sub-module; the main and skid entries are a payload struct from wb_pkg, instanced twice.

Verification
REQ-027 Bench SHALL cover: rst then in_valid=1 with M_alu_out=0x0000_1234, M_rd=3, out_ready=1 -> next cycle out_valid=1, W_alu_out=0x1234, W_rd=3.
REQ-028 Bench SHALL cover: out_ready=0 and three pushes A=0x11, B=0x22, C=0x33 -> A and B accepted, in_ready=0 after B, C held off; then out_ready=1 -> outputs A, B, C in order with no loss.
REQ-029 Bench SHALL cover: FULL state plus flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed payload never appears.
REQ-030 Bench SHALL cover: rst=1 asserted while FULL together with flush and in_valid -> EMPTY, all W_* equal 0.
REQ-031 Bench SHALL cover, with WB_PIPE_FWD_EN defined: W_wb_sel=1, W_ld_data=0xDEAD_BEEF, W_rd=7, W_reg_wen=1 -> fwd_valid=1, fwd_rd=7, fwd_data=0xDEADBEEF; and W_rd=0 -> fwd_valid=0.
REQ-032 Bench SHALL cover, without WB_PIPE_FWD_EN: the same stimulus as REQ-031 -> fwd_valid=0, fwd_rd=0, fwd_data=0.
